mem_wb_datapath: RTL and testbench

//   MIPS pipeline memory-access datapath: byte-addressed data RAM plus the MEM/WB pipeline register.

---
 rtl/mem_wb_datapath.sv | 96 +++++++++
 tb/tb_mem_wb_datapath.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_datapath.sv
//------------------------------------------------------------------------------
// Module   : mem_wb_datapath
// Brief    : MIPS memory stage. Byte-addressed big-endian data RAM feeding the
//            MEM/WB pipeline register.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_wb_datapath #(
   parameter int WORD_ADDR_W = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  load_mode,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic        reg_write,
   input  logic        mem_to_reg,
   input  logic [4:0]  wb_dest,
   output logic [31:0] read_memory_out,
   output logic [31:0] read_data,
   output logic [31:0] address_out,
   output logic        reg_write_out,
   output logic        mem_to_reg_out,
   output logic [4:0]  wb_dest_out
);

   localparam int DEPTH = 2 ** WORD_ADDR_W;

   localparam logic [1:0] LOAD_LW  = 2'b00;
   localparam logic [1:0] LOAD_LH  = 2'b01;
   localparam logic [1:0] LOAD_LB  = 2'b10;
   localparam logic [1:0] LOAD_LBU = 2'b11;

   logic [31:0]            mem [DEPTH];
   logic [WORD_ADDR_W-1:0] word_idx;
   logic [31:0]            word;
   logic [15:0]            half;
   logic [7:0]             byte_sel;

   // Upper address bits are dropped, so out-of-range addresses alias.
   assign word_idx = address[WORD_ADDR_W+1:2];
   assign word     = mem[word_idx];

   // Word-only stores; nothing is written while reset is held.
   always_ff @(posedge clk) begin
      if (mem_write && rst_n) begin
         mem[word_idx] <= write_data;
      end
   end

   // Big-endian lane selection: lowest byte offset maps to the MSBs.
   always_comb begin
      half = address[1] ? word[15:0] : word[31:16];
      case (address[1:0])
         2'b00:   byte_sel = word[31:24];
         2'b01:   byte_sel = word[23:16];
         2'b10:   byte_sel = word[15:8];
         default: byte_sel = word[7:0];
      endcase
   end

   always_comb begin
      read_memory_out = 32'h0;
      if (mem_read) begin
         case (load_mode)
            LOAD_LW:  read_memory_out = word;
            LOAD_LH:  read_memory_out = {{16{half[15]}}, half};
            LOAD_LB:  read_memory_out = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LBU: read_memory_out = {24'h0, byte_sel};
            default:  read_memory_out = 32'h0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_data      <= 32'h0;
         address_out    <= 32'h0;
         reg_write_out  <= 1'b0;
         mem_to_reg_out <= 1'b0;
         wb_dest_out    <= 5'd0;
      end else begin
         read_data      <= read_memory_out;
         address_out    <= address;
         reg_write_out  <= reg_write;
         mem_to_reg_out <= mem_to_reg;
         wb_dest_out    <= wb_dest;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_datapath.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_wb_datapath
// Brief    : Directed self-checking bench for mem_wb_datapath.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_wb_datapath;

   logic        clk;
   logic        rst_n;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  load_mode;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        reg_write;
   logic        mem_to_reg;
   logic [4:0]  wb_dest;
   logic [31:0] read_memory_out;
   logic [31:0] read_data;
   logic [31:0] address_out;
   logic        reg_write_out;
   logic        mem_to_reg_out;
   logic [4:0]  wb_dest_out;

   int vectors;
   int miscompares;

   mem_wb_datapath #(.WORD_ADDR_W(8)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .load_mode       (load_mode),
      .address         (address),
      .write_data      (write_data),
      .reg_write       (reg_write),
      .mem_to_reg      (mem_to_reg),
      .wb_dest         (wb_dest),
      .read_memory_out (read_memory_out),
      .read_data       (read_data),
      .address_out     (address_out),
      .reg_write_out   (reg_write_out),
      .mem_to_reg_out  (mem_to_reg_out),
      .wb_dest_out     (wb_dest_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs(input string tag, input logic [31:0] rd, input logic [31:0] ao,
                             input logic rw, input logic m2r, input logic [4:0] wd);
      check({tag, ".read_data"},      read_data,      rd);
      check({tag, ".address_out"},    address_out,    ao);
      check({tag, ".reg_write_out"},  {31'h0, reg_write_out},  {31'h0, rw});
      check({tag, ".mem_to_reg_out"}, {31'h0, mem_to_reg_out}, {31'h0, m2r});
      check({tag, ".wb_dest_out"},    {27'h0, wb_dest_out},    {27'h0, wd});
   endtask

   task automatic load(input string tag, input logic [1:0] mode, input logic [31:0] addr,
                       input logic [31:0] exp);
      mem_read  = 1'b1;
      mem_write = 1'b0;
      load_mode = mode;
      address   = addr;
      #1;
      check(tag, read_memory_out, exp);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      load_mode   = 2'b00;
      address     = 32'h0;
      write_data  = 32'h0;
      reg_write   = 1'b0;
      mem_to_reg  = 1'b0;
      wb_dest     = 5'd0;

      // Reset state and one-cycle latency
      #3;
      check_regs("reset", 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
      step();
      step();
      rst_n      = 1'b1;
      reg_write  = 1'b1;
      mem_to_reg = 1'b1;
      wb_dest    = 5'd9;
      address    = 32'h10;
      #1;
      check_regs("pre_edge", 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
      step();
      check_regs("latency", 32'h0, 32'h10, 1'b1, 1'b1, 5'd9);

      // Word store then load
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      wb_dest    = 5'd3;
      mem_write  = 1'b1;
      address    = 32'h20;
      write_data = 32'h8765_43A1;
      step();
      load("lw_0x20", 2'b00, 32'h20, 32'h8765_43A1);
      step();
      check("lw_reg.read_data", read_data, 32'h8765_43A1);
      check("lw_reg.wb_dest_out", {27'h0, wb_dest_out}, 32'd3);
      load("lw_0x22_ignores_low", 2'b00, 32'h22, 32'h8765_43A1);
      mem_read = 1'b0;
      #1;
      check("no_read_zero", read_memory_out, 32'h0);
      step();
      check("no_read_reg", read_data, 32'h0);

      // Halfword and byte loads
      load("lh_0x20", 2'b01, 32'h20, 32'hFFFF_8765);
      load("lh_0x22", 2'b01, 32'h22, 32'h0000_43A1);
      load("lh_0x21", 2'b01, 32'h21, 32'hFFFF_8765);
      load("lb_0x23", 2'b10, 32'h23, 32'hFFFF_FFA1);
      load("lbu_0x23", 2'b11, 32'h23, 32'h0000_00A1);
      load("lb_0x21", 2'b10, 32'h21, 32'h0000_0065);
      load("lb_0x20", 2'b10, 32'h20, 32'hFFFF_FF87);
      load("lbu_0x22", 2'b11, 32'h22, 32'h0000_0043);
      step();
      check("lbu_reg", read_data, 32'h0000_0043);

      // Wrap-around and misaligned store address
      mem_read   = 1'b0;
      mem_write  = 1'b1;
      address    = 32'h403;
      write_data = 32'hDEAD_BEEF;
      step();
      load("wrap_lw_0x000", 2'b00, 32'h0, 32'hDEAD_BEEF);
      load("wrap_lbu_0x001", 2'b11, 32'h1, 32'h0000_00AD);

      // Simultaneous read and write: old word until the edge
      mem_read   = 1'b1;
      mem_write  = 1'b1;
      load_mode  = 2'b00;
      address    = 32'h20;
      write_data = 32'h1122_3344;
      #1;
      check("rw_old", read_memory_out, 32'h8765_43A1);
      step();
      check("rw_reg_old", read_data, 32'h8765_43A1);
      mem_write = 1'b0;
      #1;
      check("rw_new", read_memory_out, 32'h1122_3344);

      // Async reset mid-stream
      reg_write  = 1'b1;
      mem_to_reg = 1'b1;
      wb_dest    = 5'd17;
      address    = 32'h20;
      step();
      check_regs("pre_reset", 32'h1122_3344, 32'h20, 1'b1, 1'b1, 5'd17);
      rst_n = 1'b0;
      #1;
      check_regs("async_reset", 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
      mem_write  = 1'b1;
      write_data = 32'hFFFF_FFFF;
      step();
      check_regs("held_reset", 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
      mem_write = 1'b0;
      rst_n     = 1'b1;
      load("after_reset_lw", 2'b00, 32'h20, 32'h1122_3344);
      load("after_reset_wrap", 2'b00, 32'h400, 32'hDEAD_BEEF);
      step();
      check_regs("first_capture", 32'hDEAD_BEEF, 32'h400, 1'b1, 1'b1, 5'd17);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
